// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
// Contents: the sixteen hex glyphs as active-low {dp,g,f,e,d,c,b,a} codes
// with the decimal point off, the all-off pattern, and the scan state type.
package seg_pkg;

   localparam logic [7:0] SEG_HEX_0 = 8'hC0;
   localparam logic [7:0] SEG_HEX_1 = 8'hF9;
   localparam logic [7:0] SEG_HEX_2 = 8'hA4;
   localparam logic [7:0] SEG_HEX_3 = 8'hB0;
   localparam logic [7:0] SEG_HEX_4 = 8'h99;
   localparam logic [7:0] SEG_HEX_5 = 8'h92;
   localparam logic [7:0] SEG_HEX_6 = 8'h82;
   localparam logic [7:0] SEG_HEX_7 = 8'hF8;
   localparam logic [7:0] SEG_HEX_8 = 8'h80;
   localparam logic [7:0] SEG_HEX_9 = 8'h90;
   localparam logic [7:0] SEG_HEX_A = 8'h88;
   localparam logic [7:0] SEG_HEX_B = 8'h83;
   localparam logic [7:0] SEG_HEX_C = 8'hC6;
   localparam logic [7:0] SEG_HEX_D = 8'hA1;
   localparam logic [7:0] SEG_HEX_E = 8'h86;
   localparam logic [7:0] SEG_HEX_F = 8'h8E;

   // All segments dark, active-low encoding.
   localparam logic [7:0] SEG_OFF   = 8'hFF;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } seg_state_t;

endpackage

// File: rtl/seg_hex_dec.sv
// Hex nibble to seven-segment pattern decoder (combinational).
// Output is always active-low; the caller applies board polarity.
// Ports:
//   i_nib  in  4  hex value 0..F
//   i_dp   in  1  decimal point, 1 = lit
//   o_seg  out 8  {dp,g,f,e,d,c,b,a}, active-low
module seg_hex_dec
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_dp,
   output logic [7:0] o_seg
);

   logic [7:0] w_code;

   always_comb begin
      w_code = SEG_OFF;
      case (i_nib)
         4'h0: w_code = SEG_HEX_0;
         4'h1: w_code = SEG_HEX_1;
         4'h2: w_code = SEG_HEX_2;
         4'h3: w_code = SEG_HEX_3;
         4'h4: w_code = SEG_HEX_4;
         4'h5: w_code = SEG_HEX_5;
         4'h6: w_code = SEG_HEX_6;
         4'h7: w_code = SEG_HEX_7;
         4'h8: w_code = SEG_HEX_8;
         4'h9: w_code = SEG_HEX_9;
         4'hA: w_code = SEG_HEX_A;
         4'hB: w_code = SEG_HEX_B;
         4'hC: w_code = SEG_HEX_C;
         4'hD: w_code = SEG_HEX_D;
         4'hE: w_code = SEG_HEX_E;
         4'hF: w_code = SEG_HEX_F;
         default: w_code = SEG_OFF;
      endcase
   end

   // Glyph codes carry bit7 = 1 (dp dark); a lit dp pulls it low.
   assign o_seg = {w_code[7] & ~i_dp, w_code[6:0]};

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous
// double buffering.
// Ports:
//   clk         in   1          system clock
//   rst_n       in   1          asynchronous active-low reset
//   data        in   4*NUM_DIG  hex nibble per digit, digit 0 rightmost
//   dp          in   NUM_DIG    decimal point per digit, 1 = lit
//   en_mask     in   NUM_DIG    per-digit enable, 0 = blanked
//   load        in   1          strobe: capture data/dp/en_mask as pending
//   dig         out  8          segments {dp,g,f,e,d,c,b,a}, registered
//   sel         out  NUM_DIG    digit selects, registered, one-hot when active
//   frame_done  out  1          one-cycle pulse as the index wraps to 0
module seg_scan_drv
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIG      = 6,
   parameter int unsigned SCAN_CYCLES  = 50_000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter bit          SEG_ACT_LOW  = 1'b1,
   parameter bit          SEL_ACT_LOW  = 1'b1
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*NUM_DIG-1:0]   data,
   input  logic [NUM_DIG-1:0]     dp,
   input  logic [NUM_DIG-1:0]     en_mask,
   input  logic                   load,
   output logic [7:0]             dig,
   output logic [NUM_DIG-1:0]     sel,
   output logic                   frame_done
);

   localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLK_LAST =
      CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

   localparam logic [7:0]         DIG_OFF = SEG_ACT_LOW ? SEG_OFF : ~SEG_OFF;
   localparam logic [NUM_DIG-1:0] SEL_OFF = SEL_ACT_LOW ? '1 : '0;

   // With no blanking interval every slot, including the first after reset,
   // begins directly in SHOW.
   localparam seg_state_t ST_SLOT0 = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   seg_state_t           r_state;
   logic [7:0]           r_dig;
   logic [NUM_DIG-1:0]   r_sel;
   logic                 r_frame_done;

   logic [4*NUM_DIG-1:0] r_act_data, r_pnd_data;
   logic [NUM_DIG-1:0]   r_act_dp,   r_pnd_dp;
   logic [NUM_DIG-1:0]   r_act_en,   r_pnd_en;
   logic                 r_pend;

   logic                 w_wrap;
   logic                 w_frame_end;
   logic [3:0]           w_nib;
   logic                 w_dp;
   logic                 w_en;
   logic [NUM_DIG-1:0]   w_hot;
   logic [7:0]           w_seg;
   logic [7:0]           w_dig_nxt;
   logic [NUM_DIG-1:0]   w_sel_nxt;

   assign w_wrap      = (r_cnt == CNT_LAST);
   assign w_frame_end = w_wrap && (r_idx == IDX_LAST);

   // Per-digit fields of the active buffer for the current index.
   always_comb begin
      w_nib = '0;
      w_dp  = 1'b0;
      w_en  = 1'b0;
      w_hot = '0;
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib    = r_act_data[4*i +: 4];
            w_dp     = r_act_dp[i];
            w_en     = r_act_en[i];
            w_hot[i] = 1'b1;
         end
      end
   end

   seg_hex_dec u_dec (
      .i_nib (w_nib),
      .i_dp  (w_dp),
      .o_seg (w_seg)
   );

   always_comb begin
      w_dig_nxt = DIG_OFF;
      w_sel_nxt = SEL_OFF;
      if (r_state == SHOW && w_en) begin
         w_dig_nxt = SEG_ACT_LOW ? w_seg : ~w_seg;
         w_sel_nxt = SEL_ACT_LOW ? ~w_hot : w_hot;
      end
   end

   // Slot counter, digit index, scan state and registered pin outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_state      <= ST_SLOT0;
         r_dig        <= DIG_OFF;
         r_sel        <= SEL_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_dig        <= w_dig_nxt;
         r_sel        <= w_sel_nxt;
         r_frame_done <= w_frame_end;
         if (w_wrap) begin
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            r_state <= ST_SLOT0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == BLANK && r_cnt == BLK_LAST)
               r_state <= SHOW;
         end
      end
   end

   // Double buffer: loads land in pending; active only changes at the frame
   // boundary. A load on the boundary cycle bypasses pending entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_data <= '0;
         r_act_dp   <= '0;
         r_act_en   <= '0;
         r_pnd_data <= '0;
         r_pnd_dp   <= '0;
         r_pnd_en   <= '0;
         r_pend     <= 1'b0;
      end else if (w_frame_end) begin
         if (load) begin
            r_act_data <= data;
            r_act_dp   <= dp;
            r_act_en   <= en_mask;
            r_pend     <= 1'b0;
         end else if (r_pend) begin
            r_act_data <= r_pnd_data;
            r_act_dp   <= r_pnd_dp;
            r_act_en   <= r_pnd_en;
            r_pend     <= 1'b0;
         end
      end else if (load) begin
         r_pnd_data <= data;
         r_pnd_dp   <= dp;
         r_pnd_en   <= en_mask;
         r_pend     <= 1'b1;
      end
   end

   assign dig        = r_dig;
   assign sel        = r_sel;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv: 3 digits, 8-cycle slots, 2 blank
// cycles, active-low segments and selects.
module tb_seg_scan_drv;

   localparam int ND    = 3;
   localparam int SLOT  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ND * SLOT;

   logic          clk;
   logic          rst_n;
   logic [11:0]   data;
   logic [2:0]    dp;
   logic [2:0]    en_mask;
   logic          load;
   logic [7:0]    dig;
   logic [2:0]    sel;
   logic          frame_done;

   seg_scan_drv #(
      .NUM_DIG      (ND),
      .SCAN_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK),
      .SEG_ACT_LOW  (1'b1),
      .SEL_ACT_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .dp         (dp),
      .en_mask    (en_mask),
      .load       (load),
      .dig        (dig),
      .sel        (sel),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model: n = clock edges since reset release. What is visible
   // after edge n was decided by the scan position at time n-1.
   int         n;
   logic [11:0] m_act_d, m_pnd_d;
   logic [2:0]  m_act_dp, m_pnd_dp, m_act_en, m_pnd_en;
   bit          m_pend;
   logic [7:0]  e_dig;
   logic [2:0]  e_sel;
   logic        e_fd;

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk8("dig", dig, e_dig);
      chk8("sel", {5'b0, sel}, {5'b0, e_sel});
      chk8("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
   endtask

   task automatic model_reset();
      n = 0;
      m_act_d = '0; m_act_dp = '0; m_act_en = '0;
      m_pnd_d = '0; m_pnd_dp = '0; m_pnd_en = '0;
      m_pend = 1'b0;
   endtask

   task automatic step();
      int pos, slot_pos, d;
      bit boundary;
      logic [3:0] nib;
      @(posedge clk);
      pos      = n % FRAME;
      slot_pos = pos % SLOT;
      d        = pos / SLOT;
      boundary = (pos == FRAME - 1);
      if (slot_pos >= BLANK && m_act_en[d]) begin
         nib   = m_act_d[4*d +: 4];
         e_dig = glyph[nib] & (m_act_dp[d] ? 8'h7F : 8'hFF);
         e_sel = ~(3'b001 << d);
      end else begin
         e_dig = 8'hFF;
         e_sel = 3'b111;
      end
      e_fd = boundary;
      if (boundary) begin
         if (load) begin
            m_act_d = data; m_act_dp = dp; m_act_en = en_mask;
            m_pend = 1'b0;
         end else if (m_pend) begin
            m_act_d = m_pnd_d; m_act_dp = m_pnd_dp; m_act_en = m_pnd_en;
            m_pend = 1'b0;
         end
      end else if (load) begin
         m_pnd_d = data; m_pnd_dp = dp; m_pnd_en = en_mask;
         m_pend = 1'b1;
      end
      n++;
      #1;
      check_outputs();
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // Advance until the next edge is at frame position p.
   task automatic run_to(input int p);
      for (int g = 0; g < 2 * FRAME && (n % FRAME) != p; g++) step();
   endtask

   task automatic do_load(input logic [11:0] d, input logic [2:0] p, input logic [2:0] e);
      data = d; dp = p; en_mask = e; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; data = '0; dp = '0; en_mask = '0; load = 1'b0;
      model_reset();
      #12;
      e_dig = 8'hFF; e_sel = 3'b111; e_fd = 1'b0;
      check_outputs();
      rst_n = 1'b1;

      // Basic display with a lit dp on digit 1, three frames of free run.
      do_load(12'h3A5, 3'b010, 3'b111);
      steps(3 * FRAME);

      // Digit 1 masked off.
      run_to(3);
      do_load(12'h3A5, 3'b010, 3'b101);
      steps(2 * FRAME);

      // Mid-frame load during slot 1 shows only from the next frame.
      run_to(10);
      do_load(12'h111, 3'b000, 3'b111);
      steps(2 * FRAME);

      // Two loads in one frame: the later one wins.
      run_to(10);
      do_load(12'h111, 3'b000, 3'b111);
      run_to(14);
      do_load(12'h222, 3'b100, 3'b111);
      steps(2 * FRAME);

      // Pending load, then a load on the boundary cycle itself.
      run_to(5);
      do_load(12'h777, 3'b000, 3'b111);
      run_to(FRAME - 1);
      do_load(12'hFED, 3'b001, 3'b111);
      steps(2 * FRAME);

      // Randomised loads and input churn.
      for (int i = 0; i < 300; i++) begin
         data    = 12'($urandom);
         dp      = 3'($urandom);
         en_mask = 3'($urandom);
         load    = ($urandom_range(0, 5) == 0);
         step();
      end
      load = 1'b0;
      steps(2 * FRAME);

      // Reset in the middle of slot 2 SHOW.
      run_to(20);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      e_dig = 8'hFF; e_sel = 3'b111; e_fd = 1'b0;
      check_outputs();
      @(negedge clk);
      model_reset();
      data = 12'hABC; dp = 3'b111; en_mask = 3'b111;
      rst_n = 1'b1;
      steps(2 * FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
